// File: rtl/fft_pkg.sv
// Shared constants, types and helpers for the 64-point FFT datapath.
package fft_pkg;

   localparam int DATA_W           = 32;
   localparam int LANES            = 8;
   localparam int SEL_W            = 3;
   localparam int GROUPS_PER_FRAME = 8;

   typedef logic [DATA_W-1:0] sample_t;
   typedef sample_t [LANES-1:0] group_t;

   // Mirror a 3-bit word index: 0,1,2,3,4,5,6,7 -> 0,4,2,6,1,5,3,7.
   function automatic logic [SEL_W-1:0] bitrev_sel(input logic [SEL_W-1:0] s);
      return {s[0], s[1], s[2]};
   endfunction

endpackage

// File: rtl/fft_group_bank.sv
// One storage bank of the ping-pong serializer: holds a whole 8-word group.
module fft_group_bank #(
   parameter int DATA_W = fft_pkg::DATA_W,
   parameter int LANES  = fft_pkg::LANES
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    we_i,
   input  logic [LANES*DATA_W-1:0] wdata_i,
   output logic [LANES*DATA_W-1:0] rdata_o
);

   logic [LANES*DATA_W-1:0] bank_q;

   // Capture a full group on write enable; cleared on reset.
   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   // NOTE: this storage is reset on purpose: out_data must read 0 after reset, not stale data.
   always_ff @(posedge clk) begin
      if (rst) begin
         bank_q <= '0;
      end else if (we_i) begin
         bank_q <= wdata_i;
      end
   end

   assign rdata_o = bank_q;

endmodule

// File: rtl/fft_group_serializer.sv
// Ping-pong group serializer: accepts 8-word groups into two banks and emits
// them one word per cycle with group/frame tracking.
// Optional macro FFT_SERIALIZER_BITREV_EN: present words in bit-reversed order.
module fft_group_serializer #(
   parameter int DATA_W = fft_pkg::DATA_W,
   parameter int LANES  = fft_pkg::LANES
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [LANES*DATA_W-1:0]    in_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [DATA_W-1:0]          out_data,
   output logic [fft_pkg::SEL_W-1:0]  out_sel,
   output logic                       out_group_last,
   output logic                       out_frame_last,
   output logic [fft_pkg::SEL_W-1:0]  group_idx
);

   import fft_pkg::SEL_W;
   import fft_pkg::GROUPS_PER_FRAME;
   import fft_pkg::bitrev_sel;

   logic [1:0]              full_q, full_d;
   logic                    wp_q, wp_d;
   logic                    rp_q, rp_d;
   logic [SEL_W-1:0]        cnt_q, cnt_d;
   logic [SEL_W-1:0]        grp_q, grp_d;

   logic                    wr_en;
   logic                    rd_en;
   logic                    last_word;
   logic [LANES*DATA_W-1:0] rdata0, rdata1, rbank;

   fft_group_bank #(.DATA_W(DATA_W), .LANES(LANES)) u_bank0 (
      .clk     (clk),
      .rst     (rst),
      .we_i    (wr_en && !wp_q),
      .wdata_i (in_data),
      .rdata_o (rdata0)
   );

   fft_group_bank #(.DATA_W(DATA_W), .LANES(LANES)) u_bank1 (
      .clk     (clk),
      .rst     (rst),
      .we_i    (wr_en && wp_q),
      .wdata_i (in_data),
      .rdata_o (rdata1)
   );

   // Handshakes come only from registered state, so a bank freed this cycle
   // becomes writable next cycle.
   assign in_ready  = !rst && !full_q[wp_q];
   assign wr_en     = in_valid && in_ready;
   assign out_valid = full_q[rp_q];
   assign rd_en     = out_valid && out_ready;
   assign last_word = (cnt_q == SEL_W'(LANES - 1));

`ifdef FFT_SERIALIZER_BITREV_EN
   assign out_sel = bitrev_sel(cnt_q);
`else
   assign out_sel = cnt_q;
`endif

   assign rbank          = rp_q ? rdata1 : rdata0;
   assign out_data       = rbank[out_sel*DATA_W +: DATA_W];
   assign out_group_last = out_valid && last_word;
   assign out_frame_last = out_group_last && (grp_q == SEL_W'(GROUPS_PER_FRAME - 1));
   assign group_idx      = grp_q;

   // Next-state for bank occupancy, pointers and word/group counters.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
      full_d = full_q;
      wp_d   = wp_q;
      rp_d   = rp_q;
      cnt_d  = cnt_q;
      grp_d  = grp_q;
      if (rd_en) begin
         if (last_word) begin
            cnt_d         = '0;
            full_d[rp_q]  = 1'b0;
            rp_d          = !rp_q;
            grp_d         = grp_q + 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
      // A write only targets an empty bank, so it never collides with the drained one.
      if (wr_en) begin
         full_d[wp_q] = 1'b1;
         wp_d         = !wp_q;
      end
   end

   // Control state register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         full_q <= '0;
         wp_q   <= 1'b0;
         rp_q   <= 1'b0;
         cnt_q  <= '0;
         grp_q  <= '0;
      end else begin
         full_q <= full_d;
         wp_q   <= wp_d;
         rp_q   <= rp_d;
         cnt_q  <= cnt_d;
         grp_q  <= grp_d;
      end
   end

endmodule

// File: tb/tb_fft_group_serializer.sv
// Directed self-checking bench for fft_group_serializer.
// Inputs change on the falling edge; outputs are checked 1 time unit later.
module tb_fft_group_serializer;

   localparam int DATA_W = 32;
   localparam int LANES  = 8;

   logic                    clk = 1'b0;
   logic                    rst;
   logic                    in_valid;
   logic                    in_ready;
   logic [LANES*DATA_W-1:0] in_data;
   logic                    out_valid;
   logic                    out_ready;
   logic [DATA_W-1:0]       out_data;
   logic [2:0]              out_sel;
   logic                    out_group_last;
   logic                    out_frame_last;
   logic [2:0]              group_idx;

   int total = 0;
   int bad   = 0;
   int gsent;

   fft_group_serializer #(.DATA_W(DATA_W), .LANES(LANES)) dut (
      .clk            (clk),
      .rst            (rst),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_data        (in_data),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_data       (out_data),
      .out_sel        (out_sel),
      .out_group_last (out_group_last),
      .out_frame_last (out_frame_last),
      .group_idx      (group_idx)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected lane for the k-th emitted word of a group.
   function automatic int esel(input int k);
`ifdef FFT_SERIALIZER_BITREV_EN
      return ((k & 1) << 2) | (k & 2) | ((k >> 2) & 1);
`else
      return k;
`endif
   endfunction

   function automatic logic [LANES*DATA_W-1:0] mk_group(input logic [31:0] base);
      logic [LANES*DATA_W-1:0] d;
      for (int k = 0; k < LANES; k++) d[k*DATA_W +: DATA_W] = base + 32'(k);
      return d;
   endfunction

   task automatic expect_word(input string tag, input logic [31:0] base, input int k, input int g);
      check({tag, "_valid"}, 64'(out_valid), 64'd1);
      check({tag, "_data"},  64'(out_data),  64'(base + 32'(esel(k))));
      check({tag, "_sel"},   64'(out_sel),   64'(esel(k)));
      check({tag, "_glast"}, 64'(out_group_last), 64'(k == 7));
      check({tag, "_flast"}, 64'(out_frame_last), 64'(k == 7 && g == 7));
      check({tag, "_gidx"},  64'(group_idx), 64'(g));
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_valid"}, 64'(out_valid), 64'd0);
      check({tag, "_data"},  64'(out_data),  64'd0);
      check({tag, "_sel"},   64'(out_sel),   64'd0);
      check({tag, "_glast"}, 64'(out_group_last), 64'd0);
      check({tag, "_flast"}, 64'(out_frame_last), 64'd0);
      check({tag, "_gidx"},  64'(group_idx), 64'd0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

      // ---- reset state ----
      repeat (2) @(negedge clk);
      #1;
      check("rst_in_ready", 64'(in_ready), 64'd0);
      check_reset_outputs("rst");
      rst = 1'b0;
      #1;
      check("post_rst_in_ready", 64'(in_ready), 64'd1);

      // ---- single group ----
      @(negedge clk);
      in_valid = 1'b1; in_data = mk_group(32'h10); out_ready = 1'b1;
      #1;
      check("single_in_ready", 64'(in_ready), 64'd1);
      check("single_pre_valid", 64'(out_valid), 64'd0);
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         in_valid = 1'b0;
         #1;
         expect_word("single", 32'h10, k, 0);
      end
      @(negedge clk);
      #1;
      check("single_empty", 64'(out_valid), 64'd0);
      check("single_gidx_next", 64'(group_idx), 64'd1);

      // ---- full frame, back-to-back ----
      do_reset();
      gsent = 0;
      out_ready = 1'b1;
      for (int c = 0; c < 66; c++) begin
         @(negedge clk);
         in_valid = (gsent < 8);
         in_data  = mk_group(32'hA000_0000 + 32'(gsent) * 32'h100);
         #1;
         if (c >= 1 && c <= 64)
            expect_word("frame", 32'hA000_0000 + 32'((c - 1) / 8) * 32'h100, (c - 1) % 8, (c - 1) / 8);
         if (c == 65) begin
            check("frame_done_valid", 64'(out_valid), 64'd0);
            check("frame_wrap_gidx", 64'(group_idx), 64'd0);
         end
         if (in_valid && in_ready) gsent++;
      end
      in_valid = 1'b0;
      check("frame_groups_accepted", 64'(gsent), 64'd8);

      // ---- backpressure at word 3 ----
      do_reset();
      @(negedge clk);
      in_valid = 1'b1; in_data = mk_group(32'h20); out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         in_valid = 1'b0;
         #1;
         expect_word("bp", 32'h20, k, 0);
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         out_ready = 1'b0;
         #1;
         expect_word("bp_stall", 32'h20, 3, 0);
      end
      @(negedge clk);
      out_ready = 1'b1;
      #1;
      expect_word("bp_release", 32'h20, 3, 0);
      for (int k = 4; k < 8; k++) begin
         @(negedge clk);
         #1;
         expect_word("bp_tail", 32'h20, k, 0);
      end
      @(negedge clk);
      #1;
      check("bp_empty", 64'(out_valid), 64'd0);

      // ---- both banks full ----
      do_reset();
      @(negedge clk);
      in_valid = 1'b1; in_data = mk_group(32'h30); out_ready = 1'b0;
      #1;
      check("full_accept_a", 64'(in_ready), 64'd1);
      @(negedge clk);
      in_data = mk_group(32'h40);
      #1;
      check("full_accept_b", 64'(in_ready), 64'd1);
      expect_word("full_hold_a", 32'h30, 0, 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         in_data = mk_group(32'h50);
         #1;
         check("full_in_ready_low", 64'(in_ready), 64'd0);
         expect_word("full_hold", 32'h30, 0, 0);
      end
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         out_ready = 1'b1;
         #1;
         check("full_drain_in_ready", 64'(in_ready), 64'd0);
         expect_word("full_drain_a", 32'h30, k, 0);
      end
      @(negedge clk);
      #1;
      check("full_freed_in_ready", 64'(in_ready), 64'd1);
      expect_word("full_b", 32'h40, 0, 1);
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      check("full_refilled_in_ready", 64'(in_ready), 64'd0);
      for (int k = 1; k < 8; k++) begin
         if (k > 1) @(negedge clk);
         #1;
         expect_word("full_b", 32'h40, k, 1);
      end
      @(negedge clk);
      #1;
      expect_word("full_c", 32'h50, 0, 2);

      // ---- reset mid-operation ----
      do_reset();
      @(negedge clk);
      in_valid = 1'b1; in_data = mk_group(32'h60); out_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         in_valid = 1'b0;
         #1;
         expect_word("mid", 32'h60, k, 0);
      end
      rst = 1'b1;
      @(negedge clk);
      #1;
      check("mid_rst_in_ready", 64'(in_ready), 64'd0);
      check_reset_outputs("mid_rst");
      rst = 1'b0;
      in_valid = 1'b1; in_data = mk_group(32'h70);
      #1;
      check("mid_post_in_ready", 64'(in_ready), 64'd1);
      check("mid_post_valid", 64'(out_valid), 64'd0);
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      expect_word("mid_new", 32'h70, 0, 0);
      @(negedge clk);
      #1;
      expect_word("mid_new", 32'h70, 1, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
